// File: rtl/ps2_dev_pkg.sv
// Shared constants, state encoding and helpers
// for the PS/2 mouse device emulator.
package ps2_dev_pkg;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] CMD_DISABLE = 8'hF5;
   localparam logic [7:0] RSP_ACK     = 8'hFA;
   localparam logic [7:0] RSP_BAT     = 8'hAA;
   localparam logic [7:0] RSP_ID      = 8'h00;
   localparam logic [7:0] RSP_RESEND  = 8'hFE;

   localparam int FRAME_BITS = 11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX,
      S_RX,
      S_RX_ACK,
      S_GAP
   } state_t;

   function automatic logic odd_par(input logic [7:0] b);
      return ~^b;
   endfunction
endpackage

// File: rtl/ps2_dev_clkgen.sv
// PS/2 clock half-period generator. Phase 0 is the
// released-high half, phase 1 the driven-low half.
module ps2_dev_clkgen #(
   parameter int CLK_HALF = 2500
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic clk_low,
   output logic rise,
   output logic fall,
   output logic sample,
   output logic high_ok
);
   localparam int CW = $clog2(CLK_HALF + 1);

   logic [CW-1:0] cnt;
   logic          ph;
   logic          half_end;

   assign half_end = en && (cnt == CW'(CLK_HALF - 1));

   // Count each half period; restart from a high half on enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         ph  <= 1'b0;
      end else if (!en) begin
         cnt <= '0;
         ph  <= 1'b0;
      end else if (half_end) begin
         cnt <= '0;
         ph  <= ~ph;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign clk_low = en && ph;
   assign rise    = half_end && ph;
   assign fall    = half_end && !ph;
   assign sample  = en && !ph && (cnt == CW'(CLK_HALF / 2));
   // Line settled high after sync latency; safe to look for contention.
   assign high_ok = en && !ph && (cnt >= CW'(3));
endmodule

// File: rtl/ps2_mouse_device.sv
// PS/2 mouse device emulator: clocks frames both ways.
// Optional PS2_RX_PARITY_EN checks host-frame parity.
module ps2_mouse_device
   import ps2_dev_pkg::*;
#(
   parameter int CLK_HALF    = 2500,
   parameter int INHIBIT_MIN = 5000,
   parameter int GAP_CLKS    = 2500
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire        ps2c,
   inout  wire        ps2d,
   input  logic       pkt_valid,
   output logic       pkt_ready,
   input  logic [8:0] dx,
   input  logic [8:0] dy,
   input  logic [2:0] btn,
   output logic       stream_en,
   output logic [7:0] cmd_byte,
   output logic       cmd_tick,
   output logic       busy
);
   localparam int IW = $clog2(INHIBIT_MIN + 1);
   localparam int GW = $clog2(GAP_CLKS + 1);

   state_t        state, state_n;
   logic [1:0]    c_sync, d_sync;
   logic          ps2c_s, ps2d_s;
   logic          c_low, d_low;
   logic          gen_en, clk_low, rise, fall;
   logic          sample, high_ok;
   logic [3:0]    bit_idx;
   logic [9:0]    rx_sh;
   logic [7:0]    q0, q1, q2;
   logic [1:0]    qcnt;
   logic [IW-1:0] inh_cnt;
   logic          inh_done, req, req_now, req_any;
   logic [GW-1:0] gap_cnt;
   logic          gap_done;
   logic [15:0]   frame;
   logic          abort, pop, cmd_done;
   logic          pkt_acc, par_ok;
   logic [7:0]    rx_data;

   assign ps2c = c_low ? 1'b0 : 1'bz;
   assign ps2d = d_low ? 1'b0 : 1'bz;

   // Two-flop synchronisers on both bus lines.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_sync <= 2'b11;
         d_sync <= 2'b11;
      end else begin
         c_sync <= {c_sync[0], ps2c};
         d_sync <= {d_sync[0], ps2d};
      end
   end

   assign ps2c_s = c_sync[1];
   assign ps2d_s = d_sync[1];

   assign gen_en = (state == S_TX) || (state == S_RX) ||
                   (state == S_RX_ACK);

   ps2_dev_clkgen #(.CLK_HALF(CLK_HALF)) u_clkgen (
      .clk     (clk),
      .rst     (rst),
      .en      (gen_en),
      .clk_low (clk_low),
      .rise    (rise),
      .fall    (fall),
      .sample  (sample),
      .high_ok (high_ok)
   );

   // Bits above the stop bit read as 1 so data is released.
   assign frame   = {5'h1F, 1'b1, odd_par(q0), q0, 1'b0};
   assign rx_data = rx_sh[7:0];

`ifdef PS2_RX_PARITY_EN
   assign par_ok = (rx_sh[8] == odd_par(rx_data));
`else
   logic unused_par;
   assign unused_par = rx_sh[8];
   assign par_ok     = 1'b1;
`endif

   assign inh_done = (inh_cnt == IW'(INHIBIT_MIN));
   assign req_now  = ps2c_s && inh_done && !ps2d_s;
   assign req_any  = req || req_now;

   assign abort    = (state == S_TX) && high_ok && !ps2c_s &&
                     (bit_idx < 4'(FRAME_BITS));
   assign pop      = (state == S_TX) && fall &&
                     (bit_idx == 4'(FRAME_BITS));
   assign cmd_done = (state == S_RX_ACK) && fall;
   assign gap_done = (state == S_GAP) &&
                     (gap_cnt == GW'(GAP_CLKS - 1));

   assign pkt_ready = (state == S_IDLE) && (qcnt == 2'd0) &&
                      stream_en && !req_any;
   assign pkt_acc   = pkt_valid && pkt_ready;
   assign busy      = (state != S_IDLE) || (qcnt != 2'd0);

   // Host request: long clock inhibit, then release with data low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inh_cnt <= '0;
         req     <= 1'b0;
      end else begin
         if (ps2c_s)
            inh_cnt <= '0;
         else if (!inh_done)
            inh_cnt <= inh_cnt + IW'(1);
         if (state == S_RX)
            req <= 1'b0;
         else if (req_now)
            req <= 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // FSM next-state logic.
   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:
            if (req_any)
               state_n = S_RX;
            else if (qcnt != 2'd0 && ps2c_s)
               state_n = S_TX;
         S_TX:
            if (abort)
               state_n = S_IDLE;
            else if (pop)
               state_n = S_GAP;
         S_RX:
            if (fall && bit_idx == 4'(FRAME_BITS - 1))
               state_n = rx_sh[9] ? S_RX_ACK : S_IDLE;
         S_RX_ACK:
            if (fall) state_n = S_GAP;
         S_GAP:
            if (gap_done) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // FSM outputs: open-drain line pulls per state.
   always_comb begin
      c_low = 1'b0;
      d_low = 1'b0;
      unique case (state)
         S_TX: begin
            c_low = clk_low;
            d_low = !frame[bit_idx];
         end
         S_RX: c_low = clk_low;
         S_RX_ACK: begin
            c_low = clk_low;
            d_low = 1'b1;
         end
         default: ;
      endcase
   end

   // Frame bit counter and host-frame shifter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_idx <= '0;
         rx_sh   <= '0;
      end else if (state != S_TX && state != S_RX) begin
         bit_idx <= '0;
      end else begin
         if (rise)
            bit_idx <= bit_idx + 4'd1;
         if (state == S_RX && sample && bit_idx != 4'd0)
            rx_sh <= {ps2d_s, rx_sh[9:1]};
      end
   end

   // Inter-byte idle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 gap_cnt <= '0;
      else if (state == S_GAP) gap_cnt <= gap_cnt + GW'(1);
      else                     gap_cnt <= '0;
   end

   // Reply queue, command execution and packet loading.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q0        <= '0;
         q1        <= '0;
         q2        <= '0;
         qcnt      <= 2'd0;
         stream_en <= 1'b0;
         cmd_byte  <= '0;
         cmd_tick  <= 1'b0;
      end else begin
         cmd_tick <= 1'b0;
         if (cmd_done) begin
            q0   <= par_ok ? RSP_ACK : RSP_RESEND;
            qcnt <= 2'd1;
            if (par_ok) begin
               cmd_byte <= rx_data;
               cmd_tick <= 1'b1;
               unique case (1'b1)
                  (rx_data == CMD_RESET): begin
                     q1        <= RSP_BAT;
                     q2        <= RSP_ID;
                     qcnt      <= 2'd3;
                     stream_en <= 1'b0;
                  end
                  (rx_data == CMD_ENABLE):  stream_en <= 1'b1;
                  (rx_data == CMD_DISABLE): stream_en <= 1'b0;
                  default: ;
               endcase
            end
         end else if (pkt_acc) begin
            q0   <= {2'b00, dy[8], dx[8], 1'b1, btn};
            q1   <= dx[7:0];
            q2   <= dy[7:0];
            qcnt <= 2'd3;
         end else if (pop) begin
            q0   <= q1;
            q1   <= q2;
            qcnt <= qcnt - 2'd1;
         end
      end
   end
endmodule

// File: tb/tb_ps2_mouse_device.sv
// Bench for ps2_mouse_device: host-side bus model,
// command vector table and packet/abort/flush sequences.
module tb_ps2_mouse_device;
   localparam int CLK_HALF    = 8;
   localparam int INHIBIT_MIN = 40;
   localparam int GAP_CLKS    = 30;
   localparam int TMO         = 4000;

   logic       clk = 1'b0;
   logic       rst;
   logic       hc, hd;
   logic       pkt_valid;
   logic       pkt_ready;
   logic [8:0] dx, dy;
   logic [2:0] btn;
   logic       stream_en;
   logic [7:0] cmd_byte;
   logic       cmd_tick;
   logic       busy;
   wire        ps2c;
   wire        ps2d;

   pullup (ps2c);
   pullup (ps2d);
   assign ps2c = hc ? 1'b0 : 1'bz;
   assign ps2d = hd ? 1'b0 : 1'bz;

   ps2_mouse_device #(
      .CLK_HALF    (CLK_HALF),
      .INHIBIT_MIN (INHIBIT_MIN),
      .GAP_CLKS    (GAP_CLKS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2c      (ps2c),
      .ps2d      (ps2d),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .dx        (dx),
      .dy        (dy),
      .btn       (btn),
      .stream_en (stream_en),
      .cmd_byte  (cmd_byte),
      .cmd_tick  (cmd_tick),
      .busy      (busy)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ticks  = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (cmd_tick === 1'b1) ticks <= ticks + 1;

   typedef struct {
      logic [7:0]  cmd;
      bit          bad;
      int          nrep;
      logic [23:0] rep;
      bit          stream;
      bit          tick;
   } vec_t;

   vec_t vecs [7];

   task automatic summary();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_level(input logic lvl, input string what);
      for (int n = 0; n < TMO; n++) begin
         if (ps2c === lvl) return;
         @(negedge clk);
      end
      checks++;
      errors++;
      $display("FAIL timeout %s: ps2c never reached %0b", what, lvl);
      summary();
      $finish;
   endtask

   task automatic host_recv(output logic [7:0] b, output bit ok,
                            output int ts, output int te);
      logic [10:0] f;
      f  = '0;
      ts = 0;
      te = 0;
      for (int k = 0; k < 11; k++) begin
         wait_level(1'b1, "rx high");
         wait_level(1'b0, "rx fall");
         f[k] = ps2d;
         if (k == 0)  ts = cyc;
         if (k == 10) te = cyc;
      end
      wait_level(1'b1, "rx end");
      b  = f[8:1];
      ok = (f[0] == 1'b0) && (f[10] == 1'b1) && (f[9] == ~^f[8:1]);
   endtask

   task automatic host_send(input logic [7:0] b, input bit bad,
                            output bit acked);
      logic [9:0] f;
      f  = {1'b1, (~^b) ^ bad, b};
      hc = 1'b1;
      repeat (INHIBIT_MIN + 10) @(negedge clk);
      hd = 1'b1;
      repeat (4) @(negedge clk);
      hc = 1'b0;
      for (int k = 0; k < 10; k++) begin
         wait_level(1'b1, "tx high");
         wait_level(1'b0, "tx fall");
         hd = ~f[k];
      end
      wait_level(1'b1, "ack high");
      wait_level(1'b0, "ack fall");
      repeat (2) @(negedge clk);
      acked = (ps2d === 1'b0);
      wait_level(1'b1, "ack end");
   endtask

   task automatic offer(input logic [8:0] x, input logic [8:0] y,
                        input logic [2:0] b);
      bit got;
      got = 1'b0;
      dx = x;
      dy = y;
      btn = b;
      pkt_valid = 1'b1;
      for (int n = 0; n < TMO && !got; n++) begin
         @(negedge clk);
         if (pkt_ready === 1'b1) got = 1'b1;
      end
      @(posedge clk);
      #1 pkt_valid = 1'b0;
      chk("pkt accepted", got, 1);
   endtask

   task automatic recv_exp(input string name, input logic [7:0] exp);
      logic [7:0] b;
      bit ok;
      int ts, te;
      host_recv(b, ok, ts, te);
      chk({name, " frame"}, ok, 1);
      chk({name, " byte"}, b, exp);
   endtask

   initial begin
      logic [7:0] b;
      bit         ok, acked;
      int         ts, te, prev_stop, t0, bad_cnt;
      logic [7:0] last_cmd;

      vecs[0] = '{8'hFF, 1'b0, 3, 24'hFAAA00, 1'b0, 1'b1};
      vecs[1] = '{8'hF4, 1'b0, 1, 24'hFA0000, 1'b1, 1'b1};
      vecs[2] = '{8'hF5, 1'b0, 1, 24'hFA0000, 1'b0, 1'b1};
      vecs[3] = '{8'h42, 1'b0, 1, 24'hFA0000, 1'b0, 1'b1};
`ifdef PS2_RX_PARITY_EN
      vecs[4] = '{8'hF4, 1'b1, 1, 24'hFE0000, 1'b0, 1'b0};
`else
      vecs[4] = '{8'hF4, 1'b1, 1, 24'hFA0000, 1'b1, 1'b1};
`endif
      vecs[5] = '{8'hF5, 1'b0, 1, 24'hFA0000, 1'b0, 1'b1};
      vecs[6] = '{8'hF4, 1'b0, 1, 24'hFA0000, 1'b1, 1'b1};

      rst = 1'b1;
      hc = 1'b0;
      hd = 1'b0;
      pkt_valid = 1'b0;
      dx = '0;
      dy = '0;
      btn = '0;
      last_cmd = 8'h00;
      prev_stop = 0;
      repeat (5) @(negedge clk);
      chk("reset ps2c", ps2c, 1);
      chk("reset ps2d", ps2d, 1);
      chk("reset stream_en", stream_en, 0);
      chk("reset pkt_ready", pkt_ready, 0);
      chk("reset busy", busy, 0);
      chk("reset cmd_byte", cmd_byte, 0);
      chk("reset cmd_tick", cmd_tick, 0);
      rst = 1'b0;

      bad_cnt = 0;
      repeat (500) begin
         @(negedge clk);
         if (ps2c !== 1'b1 || ps2d !== 1'b1 || pkt_ready !== 1'b0)
            bad_cnt++;
      end
      chk("idle lines quiet", bad_cnt, 0);

      for (int i = 0; i < 7; i++) begin
         t0 = ticks;
         host_send(vecs[i].cmd, vecs[i].bad, acked);
         chk($sformatf("v%0d ack", i), acked, 1);
         for (int r = 0; r < vecs[i].nrep; r++) begin
            host_recv(b, ok, ts, te);
            chk($sformatf("v%0d r%0d frame", i, r), ok, 1);
            chk($sformatf("v%0d r%0d byte", i, r), b,
                vecs[i].rep[23 - 8 * r -: 8]);
            if (r > 0)
               chk($sformatf("v%0d r%0d gap", i, r),
                   (ts - prev_stop >= GAP_CLKS + 2 * CLK_HALF) &&
                   (ts - prev_stop <= GAP_CLKS + 3 * CLK_HALF + 4), 1);
            prev_stop = te;
         end
         chk($sformatf("v%0d ticks", i), ticks - t0, vecs[i].tick);
         if (vecs[i].tick) last_cmd = vecs[i].cmd;
         chk($sformatf("v%0d cmd_byte", i), cmd_byte, last_cmd);
         chk($sformatf("v%0d stream_en", i), stream_en,
             vecs[i].stream);
      end

      repeat (2 * GAP_CLKS) @(negedge clk);
      chk("streaming pkt_ready", pkt_ready, 1);

      offer(9'h1F6, 9'h005, 3'b001);
      recv_exp("p1 b0", 8'h19);
      recv_exp("p1 b1", 8'hF6);
      recv_exp("p1 b2", 8'h05);

      offer(9'h003, 9'h1FE, 3'b100);
      recv_exp("p2 b0", 8'h2C);
      for (int k = 0; k < 5; k++) begin
         wait_level(1'b1, "abort high");
         wait_level(1'b0, "abort fall");
      end
      wait_level(1'b1, "abort bit5");
      repeat (3) @(negedge clk);
      hc = 1'b1;
      repeat (INHIBIT_MIN + 20) @(negedge clk);
      chk("abort data released", ps2d, 1);
      chk("abort busy", busy, 1);
      hc = 1'b0;
      recv_exp("p2 b1 resend", 8'h03);
      recv_exp("p2 b2", 8'hFE);

      offer(9'h010, 9'h020, 3'b000);
      recv_exp("p3 b0", 8'h08);
      t0 = ticks;
      host_send(8'hF5, 1'b0, acked);
      chk("flush ack", acked, 1);
      recv_exp("flush reply", 8'hFA);
      chk("flush ticks", ticks - t0, 1);
      chk("flush cmd_byte", cmd_byte, 8'hF5);
      chk("flush stream_en", stream_en, 0);
      pkt_valid = 1'b1;
      bad_cnt = 0;
      repeat (300) begin
         @(negedge clk);
         if (pkt_ready !== 1'b0 || ps2c !== 1'b1) bad_cnt++;
      end
      pkt_valid = 1'b0;
      chk("flush quiet", bad_cnt, 0);
      chk("flush busy", busy, 0);

      summary();
      $finish;
   end
endmodule
